up_control: RTL and testbench

Sequencing controller for the 8-bit nibble-instruction micro datapath. It fetches 4-bit instructions two per memory byte and decodes each one. Every cycle it drives the datapath's op select, register write strobes and memory handshake. At top level, its outputs connect to the datapath controls, to an external memory address register (MAR) loaded from datapath `data_out`, and to a memory with a req/ack handshake.

---
 rtl/up_control.sv | 185 ++++++++++++++++++
 tb/tb_up_control.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/up_control.sv
// Sequencing controller for the nibble-instruction micro datapath: fetches two
// instructions per memory byte and decodes every execute cycle combinationally.
module up_control (
  input  logic       clk,
  input  logic       nRst,
  input  logic       run,
  input  logic [3:0] ir,
  input  logic       z,
  input  logic       mem_ack,
  output logic [4:0] op,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rb_we,
  output logic       sp_we,
  output logic [2:0] rb_sel,
  output logic       mar_we,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH_A = 3'd1,
    S_FETCH_D = 3'd2,
    S_EX1     = 3'd3,
    S_EX2     = 3'd4,
    S_EX3     = 3'd5,
    S_HALTED  = 3'd6
  } state_t;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_MUL    = 5'b00010;
  localparam logic [4:0] OP_NAND   = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00101;
  localparam logic [4:0] OP_PC_SHR = 5'b10100;
  localparam logic [4:0] OP_PC_INC = 5'b10101;
  localparam logic [4:0] OP_R3     = 5'b10110;
  localparam logic [4:0] OP_SP_INC = 5'b10111;
  localparam logic [4:0] OP_SP     = 5'b11001;
  localparam logic [4:0] OP_SP_DEC = 5'b11010;
  localparam logic [4:0] OP_PC     = 5'b11011;
  localparam logic [4:0] OP_R2     = 5'b11100;
  localparam logic [4:0] OP_DIN    = 5'b11111;

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= S_RESET;
    else       state <= next_state;
  end

  // Memory states hold op/rb_sel for the whole wait; strobes only fire on ack.
  always_comb begin
    next_state = state;
    op         = OP_DIN;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rb_we      = 1'b0;
    sp_we      = 1'b0;
    rb_sel     = 3'b000;
    mar_we     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    halted     = 1'b0;
    case (state)
      S_RESET: next_state = S_FETCH_A;
      S_FETCH_A: begin
        if (run) begin
          op         = OP_PC_SHR;
          mar_we     = 1'b1;
          next_state = S_FETCH_D;
        end
      end
      S_FETCH_D: begin
        op     = OP_PC_INC;
        mem_rd = 1'b1;
        if (mem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          next_state = S_EX1;
        end
      end
      S_EX1: begin
        next_state = S_FETCH_A;
        case (ir)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            case (ir)
              4'h1:    op = OP_ADD;
              4'h2:    op = OP_SUB;
              4'h3:    op = OP_MUL;
              4'h4:    op = OP_NAND;
              default: op = OP_XOR;
            endcase
            rb_we  = 1'b1;
            rb_sel = 3'b101;
          end
          4'h6, 4'h7: begin
            op         = OP_R3;
            mar_we     = 1'b1;
            next_state = S_EX2;
          end
          4'h8: begin
            op     = OP_R2;
            rb_we  = 1'b1;
            rb_sel = 3'b111;
          end
          4'h9, 4'hD: begin
            op         = OP_SP_DEC;
            sp_we      = 1'b1;
            mar_we     = 1'b1;
            next_state = S_EX2;
          end
          4'hA, 4'hE: begin
            op         = OP_SP;
            mar_we     = 1'b1;
            next_state = S_EX2;
          end
          4'hB: begin
            op    = OP_R3;
            pc_we = z;
          end
          4'hC: begin
            op    = OP_R3;
            pc_we = 1'b1;
          end
          4'hF: next_state = S_HALTED;
          default: ;
        endcase
      end
      S_EX2: begin
        next_state = S_FETCH_A;
        case (ir)
          4'h6: begin
            mem_rd = 1'b1;
            rb_sel = 3'b000;
            rb_we  = mem_ack;
            if (!mem_ack) next_state = S_EX2;
          end
          4'h7, 4'h9: begin
            mem_wr = 1'b1;
            op     = OP_R2;
            if (!mem_ack) next_state = S_EX2;
          end
          4'hA: begin
            mem_rd     = 1'b1;
            rb_sel     = 3'b010;
            rb_we      = mem_ack;
            next_state = mem_ack ? S_EX3 : S_EX2;
          end
          4'hD: begin
            mem_wr     = 1'b1;
            op         = OP_PC;
            next_state = mem_ack ? S_EX3 : S_EX2;
          end
          4'hE: begin
            mem_rd     = 1'b1;
            pc_we      = mem_ack;
            next_state = mem_ack ? S_EX3 : S_EX2;
          end
          default: ;
        endcase
      end
      S_EX3: begin
        next_state = S_FETCH_A;
        case (ir)
          4'hA, 4'hE: begin
            op    = OP_SP_INC;
            sp_we = 1'b1;
          end
          4'hD: begin
            op    = OP_R3;
            pc_we = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALTED: halted = 1'b1;
      default: next_state = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_up_control.sv
// Directed bench for up_control: drives ir/z/mem_ack per cycle and compares the
// packed control outputs against hand-derived vectors.
module tb_up_control;

  logic       clk;
  logic       nRst;
  logic       run;
  logic [3:0] ir;
  logic       z;
  logic       mem_ack;
  logic [4:0] op;
  logic       ir_we, pc_we, rb_we, sp_we;
  logic [2:0] rb_sel;
  logic       mar_we, mem_rd, mem_wr, halted;

  int checks = 0;
  int errors = 0;

  up_control dut (
    .clk(clk), .nRst(nRst), .run(run), .ir(ir), .z(z), .mem_ack(mem_ack),
    .op(op), .ir_we(ir_we), .pc_we(pc_we), .rb_we(rb_we), .sp_we(sp_we),
    .rb_sel(rb_sel), .mar_we(mar_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] obs;
  assign obs = {op, ir_we, pc_we, rb_we, sp_we, rb_sel, mar_we, mem_rd, mem_wr, halted};

  // Expected output vector: op, ir_we, pc_we, rb_we, sp_we, rb_sel, mar_we, mem_rd, mem_wr, halted
  function automatic logic [15:0] ov(input logic [4:0] o, input logic iw, input logic pw,
                                     input logic rw, input logic sw, input logic [2:0] rs,
                                     input logic mw, input logic mr, input logic mwr,
                                     input logic h);
    return {o, iw, pw, rw, sw, rs, mw, mr, mwr, h};
  endfunction

  task automatic chk(input string tag, input logic [15:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, e);
    end
  endtask

  // One clock: compare on the falling edge, return just after the next rising edge.
  task automatic cyc(input string tag, input logic [15:0] e);
    @(negedge clk);
    chk(tag, e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] instr);
    run = 1'b1;
    mem_ack = 1'b0;
    cyc("fetch_a", ov(5'b10100, 0,0,0,0, 3'b000, 1,0,0,0));
    mem_ack = 1'b1;
    cyc("fetch_d", ov(5'b10101, 1,1,0,0, 3'b000, 0,1,0,0));
    mem_ack = 1'b0;
    ir = instr;
  endtask

  initial begin
    nRst = 1'b0; run = 1'b0; ir = 4'h0; z = 1'b0; mem_ack = 1'b0;
    #2;
    chk("reset_async", ov(5'b11111, 0,0,0,0, 3'b000, 0,0,0,0));
    cyc("reset_hold", ov(5'b11111, 0,0,0,0, 3'b000, 0,0,0,0));
    nRst = 1'b1;
    run = 1'b1;
    cyc("reset_release", ov(5'b11111, 0,0,0,0, 3'b000, 0,0,0,0));

    // ALU family, each followed by a fetch that proves the return to FETCH_A
    fetch(4'h1);
    mem_ack = 1'b1;
    cyc("add_ex1", ov(5'b00000, 0,0,1,0, 3'b101, 0,0,0,0));
    mem_ack = 1'b0;
    fetch(4'h2); cyc("sub_ex1",  ov(5'b00001, 0,0,1,0, 3'b101, 0,0,0,0));
    fetch(4'h3); cyc("mul_ex1",  ov(5'b00010, 0,0,1,0, 3'b101, 0,0,0,0));
    fetch(4'h4); cyc("nand_ex1", ov(5'b00011, 0,0,1,0, 3'b101, 0,0,0,0));
    fetch(4'h5); cyc("xor_ex1",  ov(5'b00101, 0,0,1,0, 3'b101, 0,0,0,0));
    fetch(4'h0); cyc("nop_ex1",  ov(5'b11111, 0,0,0,0, 3'b000, 0,0,0,0));
    fetch(4'h8); cyc("mov_ex1",  ov(5'b11100, 0,0,1,0, 3'b111, 0,0,0,0));

    // Jumps
    z = 1'b0;
    fetch(4'hB); cyc("jz0_ex1", ov(5'b10110, 0,0,0,0, 3'b000, 0,0,0,0));
    z = 1'b1;
    fetch(4'hB); cyc("jz1_ex1", ov(5'b10110, 0,1,0,0, 3'b000, 0,0,0,0));
    z = 1'b0;
    fetch(4'hC); cyc("jmp_ex1", ov(5'b10110, 0,1,0,0, 3'b000, 0,0,0,0));

    // LD with one wait; run dropped mid-instruction must not abort it
    fetch(4'h6);
    run = 1'b0;
    cyc("ld_ex1",  ov(5'b10110, 0,0,0,0, 3'b000, 1,0,0,0));
    cyc("ld_wait", ov(5'b11111, 0,0,0,0, 3'b000, 0,1,0,0));
    mem_ack = 1'b1;
    cyc("ld_ack",  ov(5'b11111, 0,0,1,0, 3'b000, 0,1,0,0));
    mem_ack = 1'b0;
    cyc("run0_idle", ov(5'b11111, 0,0,0,0, 3'b000, 0,0,0,0));
    mem_ack = 1'b1;
    cyc("run0_ack_ignored", ov(5'b11111, 0,0,0,0, 3'b000, 0,0,0,0));
    mem_ack = 1'b0;

    // ST zero wait
    fetch(4'h7);
    cyc("st_ex1", ov(5'b10110, 0,0,0,0, 3'b000, 1,0,0,0));
    mem_ack = 1'b1;
    cyc("st_ex2", ov(5'b11100, 0,0,0,0, 3'b000, 0,0,1,0));
    mem_ack = 1'b0;

    // PUSH with ack delayed three cycles: 7 cycles total
    fetch(4'h9);
    cyc("push_ex1", ov(5'b11010, 0,0,0,1, 3'b000, 1,0,0,0));
    for (int i = 0; i < 3; i++)
      cyc("push_wait", ov(5'b11100, 0,0,0,0, 3'b000, 0,0,1,0));
    mem_ack = 1'b1;
    cyc("push_ack", ov(5'b11100, 0,0,0,0, 3'b000, 0,0,1,0));
    mem_ack = 1'b0;

    // POP zero wait
    fetch(4'hA);
    cyc("pop_ex1", ov(5'b11001, 0,0,0,0, 3'b000, 1,0,0,0));
    mem_ack = 1'b1;
    cyc("pop_ex2", ov(5'b11111, 0,0,1,0, 3'b010, 0,1,0,0));
    mem_ack = 1'b0;
    cyc("pop_ex3", ov(5'b10111, 0,0,0,1, 3'b000, 0,0,0,0));

    // CALL then RET zero wait
    fetch(4'hD);
    cyc("call_ex1", ov(5'b11010, 0,0,0,1, 3'b000, 1,0,0,0));
    mem_ack = 1'b1;
    cyc("call_ex2", ov(5'b11011, 0,0,0,0, 3'b000, 0,0,1,0));
    mem_ack = 1'b0;
    cyc("call_ex3", ov(5'b10110, 0,1,0,0, 3'b000, 0,0,0,0));
    fetch(4'hE);
    cyc("ret_ex1", ov(5'b11001, 0,0,0,0, 3'b000, 1,0,0,0));
    mem_ack = 1'b1;
    cyc("ret_ex2", ov(5'b11111, 0,1,0,0, 3'b000, 0,1,0,0));
    mem_ack = 1'b0;
    cyc("ret_ex3", ov(5'b10111, 0,0,0,1, 3'b000, 0,0,0,0));

    // Reset pulsed during a FETCH_D wait
    run = 1'b1;
    cyc("fa_pre_rst", ov(5'b10100, 0,0,0,0, 3'b000, 1,0,0,0));
    cyc("fd_wait",    ov(5'b10101, 0,0,0,0, 3'b000, 0,1,0,0));
    #2;
    nRst = 1'b0;
    #1;
    chk("rst_mid_fd", ov(5'b11111, 0,0,0,0, 3'b000, 0,0,0,0));
    @(posedge clk);
    #1;
    nRst = 1'b1;
    cyc("rst_release2", ov(5'b11111, 0,0,0,0, 3'b000, 0,0,0,0));

    // HALT: permanent, no further fetch requests
    fetch(4'hF);
    mem_ack = 1'b1;
    cyc("halt_ex1", ov(5'b11111, 0,0,0,0, 3'b000, 0,0,0,0));
    for (int i = 0; i < 3; i++)
      cyc("halted", ov(5'b11111, 0,0,0,0, 3'b000, 0,0,0,1));
    mem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
